// File: rtl/mem_io_pkg.sv
// Shared constants and types for the mem_io_bridge memory/IO stage:
// address map, STATUS bit positions and the UART TX state encoding.
package mem_io_pkg;

    // Data RAM: 64 words at byte addresses 0x000..0x0FC
    localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
    localparam logic [31:0] RAM_LIMIT = 32'h0000_0100;
    localparam int          RAM_WORDS = 64;
    localparam int          RAM_IDX_W = 6;

    // Memory-mapped IO registers (word addresses)
    localparam logic [31:0] ADDR_TXDATA = 32'h0000_0100;
    localparam logic [31:0] ADDR_STATUS = 32'h0000_0104;
    localparam logic [31:0] ADDR_CYCLES = 32'h0000_0108;

    // STATUS register bit positions
    localparam int ST_FIFO_FULL  = 0;
    localparam int ST_TX_BUSY    = 1;
    localparam int ST_FIFO_EMPTY = 2;
    localparam int ST_OVERFLOW   = 3;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 framing, LSB first, CLKS_PER_BIT clocks per bit.
// Pulls bytes through a valid/ready pop interface; pops only from IDLE,
// so back-to-back frames are separated by exactly one idle cycle.
//
// state    | meaning
// ---------+-----------------------------------------------
// TX_IDLE  | line high, waiting for a byte from the FIFO
// TX_START | driving the start bit (low)
// TX_DATA  | shifting out 8 data bits, LSB first
// TX_STOP  | driving the stop bit (high)
module uart_tx
    import mem_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pop_valid,
    input  logic [7:0] pop_data,
    output logic       pop_ready,
    output logic       tx_busy,
    output logic       txd
);

    localparam int              BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_t         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              txd_q, txd_d;
    logic              baud_done;

    assign baud_done = (baud_q == BAUD_LAST);
    assign pop_ready = (state_q == TX_IDLE);
    assign tx_busy   = (state_q != TX_IDLE);
    assign txd       = txd_q;

    // Next-state, baud/bit counters, shift register and the line level for the next cycle
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + BAUD_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = 1'b1;
        case (state_q)
            TX_IDLE: begin
                baud_d = '0;
                if (pop_valid) begin
                    state_d = TX_START;
                    shift_d = pop_data;
                    bit_d   = '0;
                end
            end
            TX_START: begin
                if (baud_done) begin
                    state_d = TX_DATA;
                    baud_d  = '0;
                end
            end
            TX_DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = TX_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end
            end
            TX_STOP: begin
                if (baud_done) begin
                    state_d = TX_IDLE;
                    baud_d  = '0;
                end
            end
            default: begin
                state_d = TX_IDLE;
                baud_d  = '0;
            end
        endcase
        // txd is registered: derive it from the state being entered
        case (state_d)
            TX_START: txd_d = 1'b0;
            TX_DATA:  txd_d = shift_d[0];
            default:  txd_d = 1'b1;
        endcase
    end

    // FSM register; reset aborts any frame and returns the line to idle-high
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= TX_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

endmodule

// File: rtl/mem_io_bridge.sv
// Memory-side stage of the single-cycle MIPS core: 64-word data RAM,
// memory-mapped UART TX with a small FIFO and sticky overflow flag.
// Loads are combinational from addr; stores take effect on the clock edge.
// Optional feature: define MEM_IO_CYCLECOUNTER_EN to build a free-running
// 32-bit cycle counter readable (and clearable by any write) at 0x108.
module mem_io_bridge
    import mem_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        txd
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [31:0] word_addr;
    logic        unused_addr_lsbs;
    logic        sel_ram, sel_txdata, sel_status;

    // Byte offset within a word is irrelevant for this word-only map
    assign word_addr        = {addr[31:2], 2'b00};
    assign unused_addr_lsbs = ^addr[1:0];

    assign sel_ram    = (word_addr < RAM_LIMIT);
    assign sel_txdata = (word_addr == ADDR_TXDATA);
    assign sel_status = (word_addr == ADDR_STATUS);

    // ---------------------------------------------------------------
    // Data RAM (contents survive reset)
    // ---------------------------------------------------------------
    logic [31:0]          ram_q [RAM_WORDS];
    logic [RAM_IDX_W-1:0] ram_idx;

    assign ram_idx = addr[RAM_IDX_W+1:2];

    // Word store on the edge; the load path reads the pre-edge contents
    always_ff @(posedge clk) begin
        if (memwrite && sel_ram) begin
            ram_q[ram_idx] <= writedata;
        end
    end

    // ---------------------------------------------------------------
    // TX FIFO and overflow flag
    // ---------------------------------------------------------------
    logic [7:0]       fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             fifo_full, fifo_empty, fifo_not_empty;
    logic             push_req, push_ok, pop;
    logic             tx_ready, tx_busy;

    assign fifo_full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty     = (count_q == '0);
    assign fifo_not_empty = ~fifo_empty;
    assign push_req       = memwrite & sel_txdata;
    assign pop            = tx_ready & fifo_not_empty;
    // A simultaneous pop frees a slot, so a push to a full FIFO still lands
    assign push_ok        = push_req & (~fifo_full | pop);

    // Pointer/count update and sticky overflow (cleared by any STATUS write)
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop);
        ovf_d    = ovf_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (memwrite && sel_status) begin
            ovf_d = 1'b0;
        end else if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end
    end

    // FIFO control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage; no reset needed since the pointers define validity
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_q[wr_ptr_q] <= writedata[7:0];
        end
    end

    uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx (
        .clk       (clk),
        .reset     (reset),
        .pop_valid (fifo_not_empty),
        .pop_data  (fifo_q[rd_ptr_q]),
        .pop_ready (tx_ready),
        .tx_busy   (tx_busy),
        .txd       (txd)
    );

    // ---------------------------------------------------------------
    // Optional cycle counter
    // ---------------------------------------------------------------
`ifdef MEM_IO_CYCLECOUNTER_EN
    logic [31:0] cycles_q, cycles_d;
    logic        sel_cycles;

    assign sel_cycles = (word_addr == ADDR_CYCLES);

    // A write clears the counter and wins over the increment
    always_comb begin
        cycles_d = cycles_q + 32'd1;
        if (memwrite && sel_cycles) begin
            cycles_d = '0;
        end
    end

    // Cycle counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_d;
        end
    end
`endif

    // ---------------------------------------------------------------
    // Load path
    // ---------------------------------------------------------------
    logic [31:0] status_word;

    // STATUS shows registered state only, never a push in flight this cycle
    always_comb begin
        status_word                = '0;
        status_word[ST_FIFO_FULL]  = fifo_full;
        status_word[ST_TX_BUSY]    = tx_busy;
        status_word[ST_FIFO_EMPTY] = fifo_empty;
        status_word[ST_OVERFLOW]   = ovf_q;
    end

    // Combinational read mux; TXDATA and unmapped addresses read as zero
    always_comb begin
        readdata = '0;
        if (sel_ram) begin
            readdata = ram_q[ram_idx];
        end else if (sel_status) begin
            readdata = status_word;
`ifdef MEM_IO_CYCLECOUNTER_EN
        end else if (sel_cycles) begin
            readdata = cycles_q;
`endif
        end
    end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Scoreboard bench for mem_io_bridge (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// The driver advances a queue-based reference model of the FIFO and
// transmitter and pushes each expected frame (byte + start cycle) into a
// scoreboard; an independent monitor decodes txd and checks every frame.
module tb_mem_io_bridge;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        txd;

    mem_io_bridge #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .addr      (addr),
        .writedata (writedata),
        .readdata  (readdata),
        .txd       (txd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [7:0] data;
        int         start;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    logic [7:0]  m_fifo[$];
    int          m_rem = 0;
    bit          m_ovf = 1'b0;
    logic [31:0] m_ram[64];
    bit          m_ram_v[64];
    logic [31:0] m_cnt = 0;

    int abort_req  = 0;
    int abort_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a, output bit known);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        known = 1'b1;
        if (w < 32'h100) begin
            known = m_ram_v[a[7:2]];
            return m_ram[a[7:2]];
        end
        if (w == 32'h104)
            return {28'd0, m_ovf, (m_fifo.size() == 0), (m_rem > 0), (m_fifo.size() == DEPTH)};
`ifdef MEM_IO_CYCLECOUNTER_EN
        if (w == 32'h108) return m_cnt;
`endif
        return 32'd0;
    endfunction

    task automatic model_reset();
        m_fifo.delete();
        exp_q.delete();
        m_rem = 0;
        m_ovf = 1'b0;
        m_cnt = 0;
        abort_req++;
    endtask

    // Effect of one clock edge: transmitter takes the head if idle, then the store lands
    task automatic model_edge(input logic we, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] w;
        bit          take;
        exp_t        e;
        w    = {a[31:2], 2'b00};
        take = (m_rem == 0) && (m_fifo.size() != 0);
        if (take) begin
            e.data  = m_fifo.pop_front();
            e.start = cyc + 1;
            exp_q.push_back(e);
            m_rem = 10 * CPB;
        end else if (m_rem > 0) begin
            m_rem--;
        end
        if (we) begin
            if (w < 32'h100) begin
                m_ram[a[7:2]]   = d;
                m_ram_v[a[7:2]] = 1'b1;
            end
            if (w == 32'h100) begin
                if (m_fifo.size() < DEPTH) m_fifo.push_back(d[7:0]);
                else m_ovf = 1'b1;
            end
            if (w == 32'h104) m_ovf = 1'b0;
        end
        if (we && w == 32'h108) m_cnt = 0;
        else m_cnt = m_cnt + 32'd1;
    endtask

    // One bus cycle: drive, check the combinational load, advance the model, take the edge
    task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d, input logic rst);
        logic [31:0] exp_rd;
        bit          known;
        memwrite  = we;
        addr      = a;
        writedata = d;
        reset     = rst;
        #1;
        if (!rst) begin
            exp_rd = model_read(a, known);
            if (known) check($sformatf("readdata@%h", a), readdata, exp_rd);
        end
        if (rst) model_reset();
        else model_edge(we, a, d);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h104, 32'd0, 1'b0);
    endtask

    // Monitor: decode txd frames and compare against the scoreboard
    bit         mon_active = 1'b0;
    int         mon_cnt    = 0;
    int         mon_err    = 0;
    logic [7:0] mon_byte   = 8'h00;

    always @(negedge clk) begin
        exp_t cur;
        int   idx;
        logic eb;
        if (abort_req != abort_seen) begin
            abort_seen = abort_req;
            mon_active = 1'b0;
        end else if (reset === 1'b0) begin
            if (!mon_active && txd === 1'b0) begin
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL frame_start: unexpected start bit at cycle %0d, no frame expected", cyc);
                end else begin
                    cur = exp_q.pop_front();
                    if (cyc == cur.start) pass_cnt++;
                    else $display("FAIL frame_start: byte %h started at cycle %0d, expected %0d",
                                  cur.data, cyc, cur.start);
                    mon_active = 1'b1;
                    mon_cnt    = 0;
                    mon_err    = 0;
                    mon_byte   = cur.data;
                end
            end
            if (mon_active) begin
                idx = mon_cnt / CPB;
                if (idx == 0) eb = 1'b0;
                else if (idx == 9) eb = 1'b1;
                else eb = mon_byte[idx-1];
                if (txd !== eb) mon_err++;
                mon_cnt++;
                if (mon_cnt == 10 * CPB) begin
                    total_cnt++;
                    if (mon_err == 0) pass_cnt++;
                    else $display("FAIL frame_bits: byte %h had %0d wrong cycles, required 0", mon_byte, mon_err);
                    mon_active = 1'b0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rd;
        int          pick;
        bit          drained;
        reset     = 1'b1;
        memwrite  = 1'b0;
        addr      = 32'd0;
        writedata = 32'd0;
        @(posedge clk);
        #1;
        step(1'b0, 32'd0, 32'd0, 1'b1);
        step(1'b0, 32'd0, 32'd0, 1'b1);
        check("reset_txd", {31'd0, txd}, 32'd1);
        step(1'b0, 32'h104, 32'd0, 1'b0);

        // RAM: same-cycle load sees old data, next cycle sees new; unmapped reads 0
        step(1'b1, 32'h0FC, 32'h1111_1111, 1'b0);
        step(1'b1, 32'h0FC, 32'hDEAD_BEEF, 1'b0);
        step(1'b0, 32'h0FC, 32'd0, 1'b0);
        step(1'b0, 32'h0FE, 32'd0, 1'b0);
        step(1'b0, 32'h200, 32'd0, 1'b0);
        step(1'b0, 32'h100, 32'd0, 1'b0);

        // Single frame
        step(1'b1, 32'h100, 32'h0000_0055, 1'b0);
        idle(45);

        // Overflow: six back-to-back writes, then clear via STATUS write
        for (int i = 1; i <= 6; i++) step(1'b1, 32'h100, i, 1'b0);
        idle(5 * 41 + 4);
        step(1'b1, 32'h104, 32'hFFFF_FFFF, 1'b0);
        idle(2);

        // Back-to-back frames
        step(1'b1, 32'h100, 32'h0000_00A0, 1'b0);
        step(1'b1, 32'h100, 32'h0000_000F, 1'b0);
        idle(2 * 41 + 4);

        // Reset during DATA, then a clean frame
        step(1'b1, 32'h100, 32'h0000_003C, 1'b0);
        idle(10);
        step(1'b0, 32'h104, 32'd0, 1'b1);
        check("abort_txd", {31'd0, txd}, 32'd1);
        memwrite = 1'b0;
        reset    = 1'b0;
        addr     = 32'h104;
        #1;
        check("abort_status", readdata, 32'h4);
        step(1'b1, 32'h100, 32'h0000_005A, 1'b0);
        idle(45);

        // Cycle counter: clear, then read 10 cycles later
        step(1'b1, 32'h108, 32'h1234_5678, 1'b0);
        idle(10);
        memwrite = 1'b0;
        addr     = 32'h108;
        #1;
`ifdef MEM_IO_CYCLECOUNTER_EN
        check("cycles_after_10", readdata, 32'd10);
`else
        check("cycles_absent", readdata, 32'd0);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            pick = $urandom_range(0, 9);
            case (pick)
                0, 1, 2, 3: ra = {24'd0, $urandom_range(0, 7) == 0 ? 6'd63 : 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
                4, 5:       ra = 32'h100;
                6:          ra = 32'h104;
                7:          ra = 32'h108;
                8:          ra = 32'h10C + 32'($urandom_range(0, 3) * 4);
                default:    ra = $urandom;
            endcase
            rd = $urandom;
            step(($urandom_range(0, 2) == 0), ra, rd, 1'b0);
        end

        // Drain everything still queued or on the line
        drained = 1'b0;
        for (int i = 0; i < 3000 && !drained; i++) begin
            step(1'b0, 32'h104, 32'd0, 1'b0);
            drained = (m_rem == 0) && (m_fifo.size() == 0) && (exp_q.size() == 0) && !mon_active;
        end
        idle(2);
        check("drain_complete", {31'd0, drained}, 32'd1);
        check("frames_outstanding", exp_q.size() + int'(mon_active), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mem_io_bridge.md
# mem_io_bridge

Memory-side stage directly downstream of the single-cycle MIPS core: consumes `memwrite`, `aluout` (address) and `writedata`, and returns `readdata` in the same cycle. It decodes the address into a 64-word data RAM and a memory-mapped UART transmitter with a small TX FIFO. It also provides an optional cycle counter, so programs (including FPU results stored via swc1) can be emitted on a serial line.

## Interface
Parameters:
- `CLKS_PER_BIT`, 434: clock cycles per UART bit (50 MHz / 115200); legal range ≥ 2.
- `FIFO_DEPTH`, 4: TX FIFO entries; power of two, ≥ 2.

Ports:
- `clk`  in  1: single clock, all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `memwrite`  in  1: store strobe from the core.
- `addr`  in  32: byte address (core `aluout`).
- `writedata`  in  32: store data.
- `readdata`  out  32: load data, combinational from `addr`.
- `txd`  out  1: UART serial output, registered, idle high.

## Operation
Address map (word-aligned, `addr[1:0]` ignored):
- 0x000–0x0FC: data RAM, index `addr[7:2]`. Read is asynchronous. Write happens on the edge when `memwrite`=1.
- 0x100 TXDATA: a write pushes `writedata[7:0]` into the FIFO. Reads return 0.
- 0x104 STATUS (read):
  - bit0 fifo_full
  - bit1 tx_busy (FSM ≠ IDLE)
  - bit2 fifo_empty
  - bit3 overflow (sticky)
  - all other bits 0
  - Any write to 0x104 clears overflow.
- 0x108 CYCLES: present only with the macro (see Configuration).
- Any other address: reads return 0, writes are ignored.

FIFO:
- Push on a TXDATA write. Pop is issued by the FSM.
- Push while full with no pop in the same cycle: the byte is dropped and overflow is set.
- Push while full with a pop in the same cycle: the push is accepted and count stays at FIFO_DEPTH.
- Pointers wrap modulo FIFO_DEPTH.

TX FSM states:
- IDLE → START when the FIFO is non-empty. The FSM pops the head into the shift register on that edge.
- START → DATA after CLKS_PER_BIT cycles.
- DATA shifts LSB first. After 8 bits of CLKS_PER_BIT cycles each, it goes to STOP.
- STOP → IDLE after CLKS_PER_BIT cycles.
- Baud counter runs 0..CLKS_PER_BIT-1 and clears on every state change.
- `txd` by state: IDLE 1, START 0, DATA = shift[0], STOP 1.

Reset:
- FIFO emptied, overflow cleared, FSM forced to IDLE, `txd`=1, cycle counter 0.
- RAM contents are not reset.
- Reset mid-frame aborts the frame; `txd` is 1 from the next edge onward.

## Timing
- Store to RAM at edge N: a load in cycle N+1 returns the new value. A load in the same cycle as the store returns the old value.
- TXDATA write at edge N with the FSM idle and FIFO empty:
  - Edge N+1: pop, enter START.
  - `txd` is low from edge N+1 for exactly CLKS_PER_BIT cycles.
- One frame occupies exactly 10·CLKS_PER_BIT cycles.
- Back-to-back frames are separated by exactly one IDLE cycle (`txd`=1).
- STATUS reflects register state after the last edge. It does not reflect a push in the current cycle.
- `readdata` is purely combinational: no added latency to the core's single cycle.

## Configuration
- `MEM_IO_CYCLECOUNTER_EN` defined:
  - A 32-bit counter increments every cycle and wraps at 0xFFFFFFFF → 0.
  - Read at 0x108 returns the current value.
  - Any write to 0x108 clears it to 0 on that edge; this takes priority over the increment.
- Not defined: no counter is built, and 0x108 behaves as an unmapped address (reads 0).

## Structure
- Package `mem_io_pkg` holds:
  - address constants (RAM base/size, TXDATA, STATUS, CYCLES)
  - STATUS bit indices
  - TX FSM state typedef (IDLE, START, DATA, STOP)
- Sub-module `uart_tx` holds the FSM, baud counter, bit counter and shift register. Its interface is a valid/ready pop from the FIFO plus `txd`.
- Address decode, RAM, FIFO, overflow flag and cycle counter live in the top.

## Test plan
All scenarios use CLKS_PER_BIT=4, FIFO_DEPTH=4.
- Reset mid-frame:
  - Stimulus: assert reset during DATA.
  - Response: `txd`=1 next cycle; STATUS=0x4; a subsequent write produces a clean frame.
- RAM:
  - Stimulus: store 0xDEADBEEF to 0x0FC, then load 0x0FC.
  - Response: load returns 0xDEADBEEF.
  - Stimulus: load 0x200.
  - Response: returns 0.
- Single frame:
  - Stimulus: write 0x55 to 0x100.
  - Response: `txd` pattern per 4-cycle bit is 0,1,0,1,0,1,0,1,0,1, starting one cycle after the write edge; 40 cycles total; STATUS bit1=1 during the frame, 0 after.
- Overflow:
  - Stimulus: 6 consecutive TXDATA writes 0x01..0x06.
  - Response: bytes 0x01..0x05 are transmitted (0x01 popped before the FIFO fills), 0x06 is dropped, and STATUS bit3=1.
  - Stimulus: write 0x104.
  - Response: bit3=0.
- Back-to-back frames:
  - Stimulus: two queued bytes 0xA0, 0x0F.
  - Response: second start bit begins exactly one idle cycle after the first stop bit ends; STATUS bit2=1 after both frames complete.
- Cycle counter (macro on):
  - Stimulus: write 0x108; read 10 cycles later.
  - Response: returns 10.
  - Macro off: the same read returns 0.
